// File: rtl/vlc_uart_rx.sv
// VLC link serial receiver: start, 8 data bits LSB-first, parity, stop, one-entry valid/ack output.
// Define VLC_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around the sample point.
module vlc_uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_ODD   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun_err
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

`ifdef VLC_RX_MAJORITY_EN
   // The vote needs the sample after the mid-point, so every decision lands one clk later.
   localparam logic [CW-1:0] START_PT = CW'(HALF);
`else
   localparam logic [CW-1:0] START_PT = CW'(HALF - 1);
`endif

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BRK
   } state_t;

   state_t        state;
   logic [1:0]    sync;
   logic          rx_s;
   logic          bit_val;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          perr_q;
   logic          ferr_q;
   logic          pub;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= 2'b11;
      end else begin
         sync <= {sync[0], rx_in};
      end
   end

   assign rx_s = sync[1];

`ifdef VLC_RX_MAJORITY_EN
   logic [1:0] hist;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist <= 2'b11;
      end else begin
         hist <= {hist[0], rx_s};
      end
   end

   assign bit_val = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
   assign bit_val = rx_s;
`endif

   // Frame sequencer; pub pulses for one clk after the stop sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         idx    <= 3'd0;
         shreg  <= 8'h00;
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
         pub    <= 1'b0;
      end else begin
         pub <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               idx <= 3'd0;
               if (!rx_s) begin
                  state <= START;
               end
            end
            START: begin
               if (cnt == START_PT) begin
                  cnt   <= '0;
                  state <= bit_val ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == LAST) begin
                  cnt   <= '0;
                  shreg <= {bit_val, shreg[7:1]};
                  idx   <= idx + 3'd1;
                  if (idx == 3'd7) begin
                     state <= PARITY;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PARITY: begin
               if (cnt == LAST) begin
                  cnt    <= '0;
                  perr_q <= (PARITY_ODD != 0) ? ~^{shreg, bit_val} : ^{shreg, bit_val};
                  state  <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == LAST) begin
                  cnt    <= '0;
                  ferr_q <= ~bit_val;
                  pub    <= 1'b1;
                  state  <= bit_val ? IDLE : BRK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BRK: begin
               cnt <= '0;
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Holding register: a publish always wins over an ack in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data     <= 8'h00;
         rx_valid    <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else if (pub) begin
         rx_data     <= shreg;
         parity_err  <= perr_q;
         frame_err   <= ferr_q;
         rx_valid    <= 1'b1;
         overrun_err <= rx_valid & ~rx_ack;
      end else if (rx_ack && rx_valid) begin
         rx_valid    <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vlc_uart_rx.sv
// Directed bench for vlc_uart_rx: vector table of single frames plus break, overrun and reset sequences.
module tb_vlc_uart_rx;

   localparam int CPB = 16;

   logic       clk;
   logic       rst;
   logic       rx_in;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       parity_err;
   logic       frame_err;
   logic       overrun_err;

   int compared;
   int mismatched;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stp;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[5];

   vlc_uart_rx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_ODD  (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ack     (rx_ack),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun_err(overrun_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b, input int glitch_at);
      for (int c = 0; c < CPB; c++) begin
         rx_in = (c == glitch_at) ? ~b : b;
         @(negedge clk);
      end
   endtask

   // Leaves rx_in at the stop-bit level so callers can extend a break.
   task automatic applyStimulus(input logic [7:0] d, input logic p, input logic s, input int glitch_bit);
      send_bit(1'b0, -1);
      for (int i = 0; i < 8; i++) begin
         send_bit(d[i], (i == glitch_bit) ? CPB / 2 : -1);
      end
      send_bit(p, -1);
      send_bit(s, -1);
   endtask

   task automatic idle_line(input int n);
      rx_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n;
      n = 0;
      while (!rx_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, {7'd0, rx_valid}, 8'd1);
   endtask

   task automatic pulse_ack();
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_frame(input string tag, input logic [7:0] d, input logic pe, input logic fe,
                              input logic ov);
      checkOutput({tag, " rx_data"}, rx_data, d);
      checkOutput({tag, " parity_err"}, {7'd0, parity_err}, {7'd0, pe});
      checkOutput({tag, " frame_err"}, {7'd0, frame_err}, {7'd0, fe});
      checkOutput({tag, " overrun_err"}, {7'd0, overrun_err}, {7'd0, ov});
   endtask

   initial begin
      int low_hits;
      compared   = 0;
      mismatched = 0;
      rx_in      = 1'b1;
      rx_ack     = 1'b0;
      rst        = 1'b1;

      vecs[0] = '{data: 8'hA5, par: 1'b1, stp: 1'b1, exp_data: 8'hA5, exp_perr: 1'b0, exp_ferr: 1'b0};
      vecs[1] = '{data: 8'h3C, par: 1'b0, stp: 1'b1, exp_data: 8'h3C, exp_perr: 1'b1, exp_ferr: 1'b0};
      vecs[2] = '{data: 8'hFF, par: 1'b1, stp: 1'b1, exp_data: 8'hFF, exp_perr: 1'b0, exp_ferr: 1'b0};
      vecs[3] = '{data: 8'h01, par: 1'b1, stp: 1'b1, exp_data: 8'h01, exp_perr: 1'b1, exp_ferr: 1'b0};
      vecs[4] = '{data: 8'h80, par: 1'b0, stp: 1'b1, exp_data: 8'h80, exp_perr: 1'b0, exp_ferr: 1'b0};

      repeat (3) @(negedge clk);
      checkOutput("reset rx_valid", {7'd0, rx_valid}, 8'd0);
      check_frame("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      idle_line(10);

      $display("[TB] single-frame vectors");
      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v].data, vecs[v].par, vecs[v].stp, -1);
         rx_in = 1'b1;
         wait_valid($sformatf("vec%0d valid", v), 20);
         check_frame($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_ferr, 1'b0);
         repeat (2) @(negedge clk);
         pulse_ack();
         checkOutput($sformatf("vec%0d valid after ack", v), {7'd0, rx_valid}, 8'd0);
         idle_line(8);
      end

      $display("[TB] false start");
      rx_in = 1'b0;
      repeat (4) @(negedge clk);
      idle_line(200);
      checkOutput("false start valid", {7'd0, rx_valid}, 8'd0);

      $display("[TB] stop error and break");
      applyStimulus(8'h00, 1'b1, 1'b0, -1);
      wait_valid("break valid", 20);
      check_frame("break", 8'h00, 1'b0, 1'b1, 1'b0);
      pulse_ack();
      low_hits = 0;
      rx_in = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rx_valid) low_hits++;
      end
      checkOutput("break no publish", low_hits[7:0], 8'd0);
      idle_line(20);
      applyStimulus(8'h55, 1'b1, 1'b1, -1);
      rx_in = 1'b1;
      wait_valid("after break valid", 20);
      check_frame("after break", 8'h55, 1'b0, 1'b0, 1'b0);
      pulse_ack();
      idle_line(8);

      $display("[TB] back-to-back overrun");
      applyStimulus(8'h11, 1'b1, 1'b1, -1);
      checkOutput("b2b first valid", {7'd0, rx_valid}, 8'd1);
      check_frame("b2b first", 8'h11, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h22, 1'b1, 1'b1, -1);
      rx_in = 1'b1;
      wait_valid("b2b second valid", 20);
      check_frame("b2b second", 8'h22, 1'b0, 1'b0, 1'b1);
      pulse_ack();
      checkOutput("b2b valid after ack", {7'd0, rx_valid}, 8'd0);
      checkOutput("b2b overrun after ack", {7'd0, overrun_err}, 8'd0);
      idle_line(8);

      $display("[TB] reset mid-frame");
      send_bit(1'b0, -1);
      for (int i = 0; i < 3; i++) begin
         send_bit(1'b1, -1);
      end
      rst   = 1'b1;
      rx_in = 1'b1;
      @(negedge clk);
      checkOutput("mid reset rx_valid", {7'd0, rx_valid}, 8'd0);
      check_frame("mid reset", 8'h00, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle_line(200);
      checkOutput("0x77 never published", {7'd0, rx_valid}, 8'd0);
      applyStimulus(8'h81, 1'b1, 1'b1, -1);
      rx_in = 1'b1;
      wait_valid("post reset valid", 20);
      check_frame("post reset", 8'h81, 1'b0, 1'b0, 1'b0);
      pulse_ack();
      idle_line(8);

`ifdef VLC_RX_MAJORITY_EN
      $display("[TB] glitch rejection");
      applyStimulus(8'h5A, 1'b1, 1'b1, 3);
      rx_in = 1'b1;
      wait_valid("glitch valid", 20);
      check_frame("glitch", 8'h5A, 1'b0, 1'b0, 1'b0);
      pulse_ack();
      idle_line(8);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
